alu_req_arbiter: RTL and testbench



---
 rtl/alu_req_arbiter.sv | 178 +++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one external combinational ALU among NUM_REQ requesters.
//   Requests are granted round-robin. The winning operands are registered
//   and held on the ALU inputs for one cycle (MUL_LATENCY cycles for MUL),
//   so MUL can be timed as a multicycle path. Result and carry are then
//   captured and returned on one response channel, tagged with the
//   requester index.
//
//   Optional feature macro: ALU_ARB_ERR_EN
//     defined   -> rsp_err port exists; opcodes > 7 bypass the ALU and
//                  respond with rsp_result=0, rsp_carry=0, rsp_err=1.
//     undefined -> no rsp_err port; opcodes > 7 are sequenced like any
//                  single-cycle op and the ALU output is forwarded.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     req_valid/req_ready per-requester request handshake
//     req_opcode/a/b/shift packed per-requester request fields
//     alu_opcode/input1/input2/shift  registered drive to the ALU
//     alu_result/alu_carry            ALU outputs
//     rsp_valid/rsp_ready response handshake
//     rsp_id/result/carry response payload
//     rsp_err             illegal-opcode flag (ALU_ARB_ERR_EN only)
//     dbg_state           current FSM state (IDLE=0, EXEC=1, RESP=2)
//
//   Handshake rule (both channels): a transfer happens on a rising edge
//   where valid and ready are both high. The request side only needs its
//   fields stable in that cycle; rsp_* stay stable while rsp_valid is high
//   until rsp_ready is seen.
module alu_req_arbiter #(
  parameter int WIDTH       = 128,
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [4*NUM_REQ-1:0]       req_opcode,
  input  logic [WIDTH*NUM_REQ-1:0]   req_a,
  input  logic [WIDTH*NUM_REQ-1:0]   req_b,
  input  logic [5*NUM_REQ-1:0]       req_shift,
  output logic [3:0]                 alu_opcode,
  output logic [WIDTH-1:0]           alu_input1,
  output logic [WIDTH-1:0]           alu_input2,
  output logic [4:0]                 alu_shift,
  input  logic [WIDTH-1:0]           alu_result,
  input  logic                       alu_carry,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_result,
  output logic                       rsp_carry,
`ifdef ALU_ARB_ERR_EN
  output logic                       rsp_err,
`endif
  output logic [1:0]                 dbg_state
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

  localparam logic [3:0] OP_MUL = 4'd7;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;

  // Round-robin grant: first valid requester at or above ptr, wrapping.
  logic             grant_vld;
  logic [ID_W-1:0]  grant_id;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [4:0]       sel_sh;

  always_comb begin
    int j;
    grant_vld = 1'b0;
    grant_id  = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_sh    = '0;
    j         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_vld && req_valid[j]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(j);
        sel_op    = req_opcode[j*4 +: 4];
        sel_a     = req_a[j*WIDTH +: WIDTH];
        sel_b     = req_b[j*WIDTH +: WIDTH];
        sel_sh    = req_shift[j*5 +: 5];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_vld) req_ready[grant_id] = 1'b1;
  end

  // The requester just served drops to lowest priority.
  logic [ID_W-1:0] ptr_nxt;
  assign ptr_nxt = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      cnt        <= '0;
      alu_opcode <= '0;
      alu_input1 <= '0;
      alu_input2 <= '0;
      alu_shift  <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
`ifdef ALU_ARB_ERR_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            alu_opcode <= sel_op;
            alu_input1 <= sel_a;
            alu_input2 <= sel_b;
            alu_shift  <= sel_sh;
            rsp_id     <= grant_id;
            ptr        <= ptr_nxt;
            // cnt counts the extra hold cycles beyond the first.
            cnt        <= (sel_op == OP_MUL) ? CNT_W'(MUL_LATENCY - 1) : '0;
`ifdef ALU_ARB_ERR_EN
            if (sel_op[3]) begin
              // Illegal opcode: never reaches the ALU.
              rsp_result <= '0;
              rsp_carry  <= 1'b0;
              rsp_err    <= 1'b1;
              state      <= RESP;
            end else begin
              state      <= EXEC;
            end
`else
            state      <= EXEC;
`endif
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_result <= alu_result;
            rsp_carry  <= alu_carry;
`ifdef ALU_ARB_ERR_EN
            rsp_err    <= 1'b0;
`endif
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter
//   Directed bench for alu_req_arbiter. A behavioural ALU sits on the
//   alu_* ports; expected responses are pushed when a request is issued
//   and popped when the response appears.
module tb_alu_req_arbiter;

  localparam int WIDTH       = 128;
  localparam int NUM_REQ     = 4;
  localparam int MUL_LATENCY = 3;
  localparam int ID_W        = 2;
  localparam int RW          = ID_W + 2 + WIDTH;  // {id, err, carry, result}

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

`ifdef ALU_ARB_ERR_EN
  localparam int ILL_LAT = 0;
`else
  localparam int ILL_LAT = 1;
`endif

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [4*NUM_REQ-1:0]     req_opcode;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [5*NUM_REQ-1:0]     req_shift;
  logic [3:0]               alu_opcode;
  logic [WIDTH-1:0]         alu_input1;
  logic [WIDTH-1:0]         alu_input2;
  logic [4:0]               alu_shift;
  logic [WIDTH-1:0]         alu_result;
  logic                     alu_carry;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;
  logic                     rsp_carry;
`ifdef ALU_ARB_ERR_EN
  logic                     rsp_err;
`endif
  logic [1:0]               dbg_state;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_exp;
  int            n_checks;
  int            n_err;

  alu_req_arbiter #(
    .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
    .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
    .alu_shift(alu_shift), .alu_result(alu_result), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
`ifdef ALU_ARB_ERR_EN
    .rsp_err(rsp_err),
`endif
    .dbg_state(dbg_state)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Behavioural ALU: {carry, result}
  function automatic logic [WIDTH:0] alu_ref(input logic [3:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [4:0] sh);
    logic [2*WIDTH-1:0] p;
    logic [WIDTH:0]     r;
    p = '0;
    case (op)
      4'd0: r = {1'b0, a} + {1'b0, b};
      4'd1: r = {1'b0, a} - {1'b0, b};
      4'd2: r = {1'b0, a & b};
      4'd3: r = {1'b0, a | b};
      4'd4: r = {1'b0, (a << sh) | (a >> (WIDTH - int'(sh)))};
      4'd5: r = {1'b0, b};
      4'd6: r = {1'b0, (a >> sh) | (a << (WIDTH - int'(sh)))};
      4'd7: begin
        p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
        r = {|p[2*WIDTH-1:WIDTH], p[WIDTH-1:0]};
      end
      default: r = {1'b1, a ^ b};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_result} = alu_ref(alu_opcode, alu_input1, alu_input2, alu_shift);

  function automatic logic [WIDTH-1:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_req(input int i, input logic [3:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [4:0] sh);
    req_opcode[i*4 +: 4]       = op;
    req_a[i*WIDTH +: WIDTH]    = a;
    req_b[i*WIDTH +: WIDTH]    = b;
    req_shift[i*5 +: 5]        = sh;
    req_valid[i]               = 1'b1;
  endtask

  task automatic push_exp(input int i, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [4:0] sh);
    logic [WIDTH:0] r;
    logic           err;
    r   = alu_ref(op, a, b, sh);
    err = 1'b0;
`ifdef ALU_ARB_ERR_EN
    if (op > 4'd7) begin
      r   = '0;
      err = 1'b1;
    end
`endif
    exp_q.push_back({ID_W'(i), err, r});
  endtask

  task automatic pop_check(input string tag);
    check({tag, "_valid"}, RW'(rsp_valid), RW'(1));
    check({tag, "_avail"}, RW'(exp_q.size() != 0), RW'(1));
    if (exp_q.size() != 0) last_exp = exp_q.pop_front();
    else last_exp = '0;
    check({tag, "_id"},     RW'(rsp_id),     RW'(last_exp[RW-1 -: ID_W]));
    check({tag, "_result"}, RW'(rsp_result), RW'(last_exp[WIDTH-1:0]));
    check({tag, "_carry"},  RW'(rsp_carry),  RW'(last_exp[WIDTH]));
`ifdef ALU_ARB_ERR_EN
    check({tag, "_err"},    RW'(rsp_err),    RW'(last_exp[WIDTH+1]));
`endif
  endtask

  // Called #1 after the accept edge; checks operand hold, latency, payload.
  task automatic wait_rsp(input int exp_lat, input logic [3:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [4:0] sh, input string tag);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      check({tag, "_hold_op"}, RW'(alu_opcode), RW'(op));
      check({tag, "_hold_a"},  RW'(alu_input1), RW'(a));
      check({tag, "_hold_b"},  RW'(alu_input2), RW'(b));
      check({tag, "_hold_sh"}, RW'(alu_shift),  RW'(sh));
      check({tag, "_exec"},    RW'(dbg_state),  RW'(S_EXEC));
      check({tag, "_noready"}, RW'(req_ready),  RW'(0));
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, RW'(lat), RW'(exp_lat));
    pop_check(tag);
  endtask

  // Single request, rsp_ready assumed high; starts and ends #1 after an edge in IDLE.
  task automatic run_op(input int i, input logic [3:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [4:0] sh,
                        input int exp_lat, input string tag);
    set_req(i, op, a, b, sh);
    #1;
    check({tag, "_ready"}, RW'(req_ready), RW'(1 << i));
    push_exp(i, op, a, b, sh);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    wait_rsp(exp_lat, op, a, b, sh, tag);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [WIDTH-1:0] ta, tb;
  logic [4:0]       ts;
  logic [WIDTH-1:0] rr_a[NUM_REQ];
  logic [WIDTH-1:0] rr_b[NUM_REQ];
  int               order[5];

  initial begin
    n_checks   = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_shift  = '0;
    rsp_ready  = 1'b1;
    order      = '{0, 1, 2, 3, 0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",  RW'(dbg_state),  RW'(S_IDLE));
    check("rst_ready",  RW'(req_ready),  RW'(0));
    check("rst_valid",  RW'(rsp_valid),  RW'(0));
    check("rst_id",     RW'(rsp_id),     RW'(0));
    check("rst_result", RW'(rsp_result), RW'(0));
    check("rst_carry",  RW'(rsp_carry),  RW'(0));
    check("rst_aluop",  RW'(alu_opcode), RW'(0));
    check("rst_alua",   RW'(alu_input1), RW'(0));
    check("rst_alub",   RW'(alu_input2), RW'(0));
    check("rst_alush",  RW'(alu_shift),  RW'(0));
`ifdef ALU_ARB_ERR_EN
    check("rst_err",    RW'(rsp_err),    RW'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD wrap-around: result 0, carry 1
    run_op(0, 4'd0, {WIDTH{1'b1}}, WIDTH'(1), 5'd0, 1, "add_wrap");

    // Other single-cycle opcodes with random operands
    for (int op = 1; op <= 6; op++) begin
      ta = rand128();
      tb = rand128();
      ts = 5'($urandom_range(0, 31));
      run_op(op % NUM_REQ, 4'(op), ta, tb, ts, 1, $sformatf("op%0d", op));
    end

    // MUL held for MUL_LATENCY cycles
    run_op(2, 4'd7, WIDTH'(3), WIDTH'(5), 5'd0, MUL_LATENCY, "mul_small");
    ta = rand128();
    tb = rand128();
    run_op(1, 4'd7, ta, tb, 5'd3, MUL_LATENCY, "mul_big");

    // Round-robin with all requesters pending; start from a fresh pointer
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      rr_a[i] = rand128();
      rr_b[i] = rand128();
      set_req(i, 4'(i), rr_a[i], rr_b[i], 5'd0);
    end
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("rr%0d_grant", k), RW'(req_ready), RW'(1 << order[k]));
      check($sformatf("rr%0d_onehot", k), RW'($onehot0(req_ready)), RW'(1));
      push_exp(order[k], 4'(order[k]), rr_a[order[k]], rr_b[order[k]], 5'd0);
      @(posedge clk); #1;
      wait_rsp(1, 4'(order[k]), rr_a[order[k]], rr_b[order[k]], 5'd0, $sformatf("rr%0d", k));
      @(posedge clk);
    end
    #1;
    req_valid = '0;

    // Backpressure: RESP held, payload stable, no new grants
    rsp_ready = 1'b0;
    ta = rand128();
    tb = rand128();
    set_req(3, 4'd1, ta, tb, 5'd0);
    #1;
    check("bp_ready", RW'(req_ready), RW'(4'b1000));
    push_exp(3, 4'd1, ta, tb, 5'd0);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    set_req(1, 4'd0, tb, ta, 5'd0);
    wait_rsp(1, 4'd1, ta, tb, 5'd0, "bp");
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_hold_valid",  RW'(rsp_valid),  RW'(1));
      check("bp_hold_state",  RW'(dbg_state),  RW'(S_RESP));
      check("bp_hold_id",     RW'(rsp_id),     RW'(last_exp[RW-1 -: ID_W]));
      check("bp_hold_result", RW'(rsp_result), RW'(last_exp[WIDTH-1:0]));
      check("bp_hold_carry",  RW'(rsp_carry),  RW'(last_exp[WIDTH]));
      check("bp_hold_noready", RW'(req_ready), RW'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_next_grant", RW'(req_ready), RW'(4'b0010));
    push_exp(1, 4'd0, tb, ta, 5'd0);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_rsp(1, 4'd0, tb, ta, 5'd0, "bp_next");
    @(posedge clk); #1;

    // Reset in the middle of a MUL (cnt=1): no response, pointer cleared
    ta = rand128();
    tb = rand128();
    set_req(2, 4'd7, ta, tb, 5'd0);
    #1;
    check("rstmul_ready", RW'(req_ready), RW'(4'b0100));
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("rstmul_exec", RW'(dbg_state), RW'(S_EXEC));
    rst_n = 1'b0;
    #1;
    check("rstmul_state", RW'(dbg_state),  RW'(S_IDLE));
    check("rstmul_valid", RW'(rsp_valid),  RW'(0));
    check("rstmul_alua",  RW'(alu_input1), RW'(0));
    check("rstmul_aluop", RW'(alu_opcode), RW'(0));
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rstmul_quiet", RW'(rsp_valid), RW'(0));
    end
    rst_n = 1'b1;
    ta = rand128();
    tb = rand128();
    set_req(3, 4'd2, tb, ta, 5'd0);
    set_req(0, 4'd3, ta, tb, 5'd0);
    #1;
    check("rstmul_regrant", RW'(req_ready), RW'(4'b0001));
    push_exp(0, 4'd3, ta, tb, 5'd0);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(1, 4'd3, ta, tb, 5'd0, "rstmul_next");
    @(posedge clk); #1;

    // Illegal opcode
    ta = rand128();
    tb = rand128();
    run_op(1, 4'd9, ta, tb, 5'd0, ILL_LAT, "illegal");

    check("queue_empty", RW'(exp_q.size()), RW'(0));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
